// File: rtl/bpb_pkg.sv
// bpb_pkg: shared defaults, types and helpers for the gshare branch direction predictor.
//   DEF_*        default parameter values for gshare_bpb
//   pred_rsp_t   registered prediction response {taken, hist}
//   ctr_init()   weakly-not-taken counter reset value for a given counter width
//   idx()        table index from PC bits XOR history (history zero-extended to the index width)
package bpb_pkg;

  localparam int DEF_INDEX_W = 10;
  localparam int DEF_CTR_W   = 2;
  localparam int DEF_HIST_W  = 8;
  localparam int DEF_PC_LSB  = 2;
  localparam int HIST_W_MAX  = 32;

  // hist is held at the widest supported history; the top level exposes the low HIST_W bits
  typedef struct packed {
    logic                  taken;
    logic [HIST_W_MAX-1:0] hist;
  } pred_rsp_t;

  // 2^(ctr_w-1)-1: the weakly not-taken state
  function automatic logic [31:0] ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

  // pc[pc_lsb+index_w-1:pc_lsb] ^ hist, masked to index_w bits
  function automatic logic [31:0] idx(input logic [31:0]  pc,
                                      input logic [31:0]  hist,
                                      input int unsigned  index_w,
                                      input int unsigned  pc_lsb);
    logic [31:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return ((pc >> pc_lsb) ^ hist) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: CTR_W-bit saturating up/down counter, one per predictor table entry.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, loads INIT
//   en_i   in   this entry is being trained this cycle
//   inc_i  in   1 = count up (taken), 0 = count down (not taken)
//   msb_o  out  counter MSB (predicted direction)
module sat_counter #(
  parameter int               CTR_W = 2,
  parameter logic [CTR_W-1:0] INIT  = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic inc_i,
  output logic msb_o
);

  localparam logic [CTR_W-1:0] MAX = '1;
  localparam logic [CTR_W-1:0] MIN = '0;

  logic [CTR_W-1:0] ctr_q, ctr_d;

  // Saturating increment/decrement when selected
  always_comb begin
    ctr_d = ctr_q;
    if (en_i) begin
      if (inc_i) begin
        if (ctr_q != MAX) ctr_d = ctr_q + CTR_W'(1);
        else              ctr_d = ctr_q;
      end else begin
        if (ctr_q != MIN) ctr_d = ctr_q - CTR_W'(1);
        else              ctr_d = ctr_q;
      end
    end else begin
      ctr_d = ctr_q;
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= INIT;
    else        ctr_q <= ctr_d;
  end

  assign msb_o = ctr_q[CTR_W-1];

endmodule

// File: rtl/gshare_bpb.sv
// gshare_bpb: branch direction predictor for Fetch. 2^INDEX_W saturating counters indexed by
// PC bits XOR a global history register (GHR). Prediction is registered (1-cycle latency) and
// returns the GHR snapshot it used; commit-time updates train counters and repair the GHR.
//   clk, reset (async, active-low)
//   pred_req/pred_pc                       -> pred_valid/pred_taken/pred_hist (next cycle)
//   upd_valid/upd_pc/upd_hist/upd_taken/upd_mispredict  training and history repair
// Build option: define BPB_GSHARE_EN for XOR indexing with a GHR. Without it the predictor is
// bimodal: the index is PC bits only, GHR stays 0, pred_hist is 0 and upd_hist/repair are ignored.
module gshare_bpb
  import bpb_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CTR_W   = DEF_CTR_W,
  parameter int HIST_W  = DEF_HIST_W,
  parameter int PC_LSB  = DEF_PC_LSB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispredict
);

  localparam int               DEPTH = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] INIT  = CTR_W'(ctr_init(CTR_W));

  logic [HIST_W-1:0]  ghr_q, ghr_d;
  logic [HIST_W-1:0]  uhist_s;
  logic [INDEX_W-1:0] pidx_s, uidx_s;
  logic [DEPTH-1:0]   msb_s, wsel_s;
  logic               pmsb_s;
  logic               pred_valid_q, pred_valid_d;
  pred_rsp_t          rsp_q, rsp_d;
  logic               unused_s;

`ifdef BPB_GSHARE_EN
  assign uhist_s = upd_hist;
`else
  assign uhist_s = '0;
`endif

  assign pidx_s = INDEX_W'(idx(pred_pc, 32'(ghr_q), INDEX_W, PC_LSB));
  assign uidx_s = INDEX_W'(idx(upd_pc, 32'(uhist_s), INDEX_W, PC_LSB));
  assign pmsb_s = msb_s[pidx_s];

  // One-hot write select; the prediction read above sees the pre-update counter
  assign wsel_s = upd_valid ? ({{(DEPTH-1){1'b0}}, 1'b1} << uidx_s) : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    sat_counter #(
      .CTR_W (CTR_W),
      .INIT  (INIT)
    ) u_ctr (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (wsel_s[g]),
      .inc_i (upd_taken),
      .msb_o (msb_s[g])
    );
  end

  // GHR next state: a commit-time repair wins over the speculative shift
  always_comb begin
    ghr_d = ghr_q;
`ifdef BPB_GSHARE_EN
    if (upd_valid && upd_mispredict) begin
      ghr_d = HIST_W'({upd_hist, upd_taken});
    end else if (pred_req) begin
      ghr_d = HIST_W'({ghr_q, pmsb_s});
    end else begin
      ghr_d = ghr_q;
    end
`else
    ghr_d = '0;
`endif
  end

  // Prediction response next state; taken/hist hold when no request
  always_comb begin
    pred_valid_d = pred_req;
    rsp_d        = rsp_q;
    if (pred_req) begin
      rsp_d.taken = pmsb_s;
      rsp_d.hist  = HIST_W_MAX'(ghr_q);
    end else begin
      rsp_d = rsp_q;
    end
  end

  // GHR and prediction output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      rsp_q        <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      rsp_q        <= rsp_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = rsp_q.taken;
  assign pred_hist  = rsp_q.hist[HIST_W-1:0];

  // PC bits outside the index window, and inputs unused in the bimodal build
  assign unused_s = ^{pred_pc, upd_pc, upd_hist, upd_mispredict, rsp_q};

endmodule
